// File: rtl/sine_cos_gen.sv
// Quadrature DDS: an 8-bit phase accumulator drives a quarter-wave sine ROM.
// The ROM is folded by quadrant so that sine and cosine come out 90 degrees apart.
module sine_cos_gen #(
  parameter logic [7:0] PHASE_STEP = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] sine,
  output logic [7:0] cos
);

  logic [7:0] phase;
  logic [7:0] sine_q;
  logic [7:0] cos_q;
  logic [7:0] pn;

  // Q[i] = round(127*sin(2*pi*i/256)), i = 0..64
  function automatic logic [6:0] quarter(input logic [6:0] i);
    logic [6:0] v;
    case (i)
      7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;    7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;   7'd5:  v = 7'd16;   7'd6:  v = 7'd19;   7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;   7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
      7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;   7'd15: v = 7'd46;
      7'd16: v = 7'd49;   7'd17: v = 7'd51;   7'd18: v = 7'd54;   7'd19: v = 7'd57;
      7'd20: v = 7'd60;   7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
      7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;   7'd27: v = 7'd78;
      7'd28: v = 7'd81;   7'd29: v = 7'd83;   7'd30: v = 7'd85;   7'd31: v = 7'd88;
      7'd32: v = 7'd90;   7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
      7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;  7'd39: v = 7'd104;
      7'd40: v = 7'd106;  7'd41: v = 7'd107;  7'd42: v = 7'd109;  7'd43: v = 7'd111;
      7'd44: v = 7'd112;  7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
      7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;  7'd51: v = 7'd121;
      7'd52: v = 7'd122;  7'd53: v = 7'd122;  7'd54: v = 7'd123;  7'd55: v = 7'd124;
      7'd56: v = 7'd125;  7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
      7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;  7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Odd quadrants read the table mirrored, the upper half is negated.
  function automatic logic [7:0] fold(input logic [7:0] p);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = {1'b0, quarter(idx)};
    return p[7] ? (8'd0 - mag) : mag;
  endfunction

  assign pn = phase + PHASE_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= 8'd0;
      sine_q <= 8'h00;
      cos_q  <= 8'h7F;
    end else if (en) begin
      phase  <= pn;
      sine_q <= fold(pn);
      cos_q  <= fold(pn + 8'd64);
    end
  end

  assign sine = sine_q;
  assign cos  = cos_q;

endmodule

// File: tb/tb_sine_cos_gen.sv
// Bench for sine_cos_gen: directed sweeps and random enables checked against a
// real-valued sin() reference, with one instance at step 1 and one at step 3.
module tb_sine_cos_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, en3;
  logic [7:0] sine1, cos1, sine3, cos3;

  int errors = 0;
  int checks = 0;
  int ph1 = 0;
  int ph3 = 0;
  logic [7:0] sweep_s [256];
  logic [7:0] sweep_c [256];

  localparam real PI = 3.14159265358979;

  sine_cos_gen #(.PHASE_STEP(8'd1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .sine(sine1), .cos(cos1));
  sine_cos_gen #(.PHASE_STEP(8'd3)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .sine(sine3), .cos(cos3));

  always #5 clk = ~clk;

  function automatic logic [7:0] s_ref(input int p);
    real r;
    int  v;
    r = 127.0 * $sin(2.0 * PI * real'(p % 256) / 256.0);
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return 8'(v);
  endfunction

  function automatic logic [7:0] c_ref(input int p);
    return s_ref((p + 64) % 256);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en1 = 1'b0; en3 = 1'b0;
    repeat (5) tick();
    chk("reset_sine", sine1, 8'h00);
    chk("reset_cos", cos1, 8'h7F);

    // idle after reset: outputs must not move
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      chk("idle_sine", sine1, 8'h00);
      chk("idle_cos", cos1, 8'h7F);
    end

    // full sweep at step 1, landmarks plus reference at every phase
    ph1 = 0;
    sweep_s[0] = sine1; sweep_c[0] = cos1;
    en1 = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      tick();
      ph1 = n % 256;
      if (n < 256) begin
        sweep_s[n] = sine1; sweep_c[n] = cos1;
      end
      chk("sweep_sine", sine1, s_ref(ph1));
      chk("sweep_cos", cos1, c_ref(ph1));
      case (n)
        1:   begin chk("n1_sine", sine1, 8'd3);   chk("n1_cos", cos1, 8'd127); end
        32:  begin chk("n32_sine", sine1, 8'd90); chk("n32_cos", cos1, 8'd90); end
        64:  begin chk("n64_sine", sine1, 8'd127); chk("n64_cos", cos1, 8'd0); end
        128: begin chk("n128_sine", sine1, 8'd0); chk("n128_cos", cos1, 8'h81); end
        192: begin chk("n192_sine", sine1, 8'h81); chk("n192_cos", cos1, 8'd0); end
        256: begin chk("wrap_sine", sine1, 8'd0); chk("wrap_cos", cos1, 8'd127); end
        default: ;
      endcase
    end
    for (int p = 0; p < 256; p++) begin
      chk("odd_sym", sweep_s[p], 8'd0 - sweep_s[(p + 128) % 256]);
      chk("quad_sym", sweep_c[p], sweep_s[(p + 64) % 256]);
      checks++;
      assert (sweep_s[p] !== 8'h80 && sweep_c[p] !== 8'h80) else begin
        errors++;
        $error("FAIL no_0x80 at phase %0d: sine %0d cos %0d", p, $signed(sweep_s[p]), $signed(sweep_c[p]));
      end
    end

    // random enable pattern
    for (int i = 0; i < 400; i++) begin
      en1 = 1'($urandom % 2);
      tick();
      if (en1) ph1 = (ph1 + 1) % 256;
      chk("rand_sine", sine1, s_ref(ph1));
      chk("rand_cos", cos1, c_ref(ph1));
    end

    // reach phase 100, then reset together with en
    reset = 1'b1; en1 = 1'b0;
    tick();
    reset = 1'b0; en1 = 1'b1;
    repeat (100) tick();
    chk("ph100_sine", sine1, s_ref(100));
    reset = 1'b1;
    tick();
    chk("midrst_sine", sine1, 8'h00);
    chk("midrst_cos", cos1, 8'h7F);
    reset = 1'b0;
    repeat (64) tick();
    chk("post_rst_sine", sine1, 8'd127);
    chk("post_rst_cos", cos1, 8'd0);
    en1 = 1'b0;

    // step 3 with en toggling every cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ph3 = 0;
    for (int i = 0; i < 200; i++) begin
      en3 = (i % 2 == 0);
      tick();
      if (en3) ph3 = (ph3 + 3) % 256;
      chk("tog_sine", sine3, s_ref(ph3));
      chk("tog_cos", cos3, c_ref(ph3));
    end
    en3 = 1'b0;
    chk("step3_end_sine", sine3, s_ref(44));
    chk("step3_end_cos", cos3, c_ref(44));
    tick();
    chk("step3_hold_sine", sine3, s_ref(44));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
